uart_boot_loader: RTL and testbench

//   Upstream stage of the on-chip SRAM in the flash-less emulation build. Receives a framed firmware image

---
 rtl/boot_pkg.sv | 21 ++
 rtl/uart_rx_byte.sv | 86 ++++++++
 rtl/uart_boot_loader.sv | 174 +++++++++++++++++
 tb/tb_uart_boot_loader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// boot_pkg: constants and the FSM state type shared by the UART boot loader.
//   BOOT_MAGIC      - first byte of every boot frame
//   CLK_DIV_DEFAULT - clocks per UART bit at 50 MHz / 115200 baud
//   boot_state_t    - frame-parser FSM states
package boot_pkg;

  localparam logic [7:0] BOOT_MAGIC      = 8'hA5;
  localparam int         CLK_DIV_DEFAULT = 434;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CSUM,
    DONE,
    ERROR
  } boot_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver (2-flop synchroniser, bit timer, shifter).
// Ports:
//   clk, resetn   system clock, async active-low reset
//   rx            async serial line, idle high
//   rx_valid      1-cycle pulse, rx_byte holds the received byte
//   rx_byte[7:0]  last good byte (LSB received first)
//   rx_ferr       1-cycle pulse when the stop bit is sampled low; byte discarded
module uart_rx_byte
  import boot_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_ferr
);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

  localparam logic [15:0] HALF = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] FULL = 16'(CLK_DIV - 1);

  rx_state_t   st;
  logic [1:0]  sync;
  logic        rx_q;
  logic [15:0] cnt;
  logic [2:0]  bitn;
  logic [7:0]  shreg;
  logic        rx_s;

  assign rx_s = sync[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // Synchroniser resets to the idle level so release is not seen as a start edge.
      sync     <= 2'b11;
      rx_q     <= 1'b1;
      st       <= RX_IDLE;
      cnt      <= '0;
      bitn     <= '0;
      shreg    <= '0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
      rx_ferr  <= 1'b0;
    end else begin
      sync     <= {sync[0], rx};
      rx_q     <= rx_s;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (st)
        // Edge detect (not level) so a line stuck low after a framing error
        // cannot retrigger until it has returned high.
        RX_IDLE: if (rx_q && !rx_s) begin
          st  <= RX_START;
          cnt <= '0;
        end
        RX_START: if (cnt == HALF) begin
          cnt  <= '0;
          bitn <= '0;
          st   <= rx_s ? RX_IDLE : RX_BITS;  // glitch rejection
        end else cnt <= cnt + 16'd1;
        RX_BITS: if (cnt == FULL) begin
          cnt   <= '0;
          shreg <= {rx_s, shreg[7:1]};
          bitn  <= bitn + 3'd1;
          if (bitn == 3'd7) st <= RX_STOP;
        end else cnt <= cnt + 16'd1;
        RX_STOP: if (cnt == FULL) begin
          cnt <= '0;
          st  <= RX_IDLE;
          if (rx_s) begin
            rx_valid <= 1'b1;
            rx_byte  <= shreg;
          end else begin
            rx_ferr <= 1'b1;
          end
        end else cnt <= cnt + 16'd1;
        default: st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// uart_boot_loader: receives a framed firmware image over UART, writes it into
// the 512x32 SRAM and releases the CPU reset once the checksum matches.
// Frame: A5, LEN_LO, LEN_HI, LEN x 4 little-endian data bytes, 8-bit sum of data.
// Optional build macro BOOT_TIMEOUT_EN: if no magic byte ever arrives within
// TIMEOUT_CYCLES of reset, boot the preloaded image anyway.
// Ports:
//   clk, resetn          system clock, async active-low reset
//   uart_rx              async serial input, 8N1, idle high
//   mem_wen[3:0]         SRAM byte enables, 4'hF for exactly one cycle per word
//   mem_addr[ADDR_W-1:0] SRAM word address (held between writes)
//   mem_wdata[31:0]      SRAM write data (held between writes)
//   cpu_resetn           0 holds the CPU in reset
//   boot_busy            high from magic byte until DONE/ERROR
//   boot_err             sticky frame failure, cleared by the next magic byte
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEFAULT,
  parameter int WORDS   = 512,
  parameter int ADDR_W  = 9
`ifdef BOOT_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 50000000
`endif
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              uart_rx,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_resetn,
  output logic              boot_busy,
  output logic              boot_err
);

  // One extra bit so the index can reach LEN == WORDS.
  localparam int          CW      = ADDR_W + 1;
  localparam logic [15:0] WORDS16 = 16'(WORDS);

  boot_state_t state;
  logic        rx_valid, rx_ferr;
  logic [7:0]  rx_byte;
  logic [7:0]  len_lo, sum;
  logic [CW-1:0] len, idx, idx_nxt;
  logic [1:0]  bi;
  logic [31:0] wbuf, word_nxt;
  logic [15:0] len_full;
  logic        in_frame;

`ifdef BOOT_TIMEOUT_EN
  logic [31:0] to_cnt;
  logic        magic_seen;
`endif

  uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk      (clk),
    .resetn   (resetn),
    .rx       (uart_rx),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .rx_ferr  (rx_ferr)
  );

  always_comb begin
    word_nxt              = wbuf;
    word_nxt[8*bi +: 8]   = rx_byte;
  end

  assign len_full = {rx_byte, len_lo};
  assign idx_nxt  = idx + 1'b1;
  assign in_frame = (state == LEN_LO) || (state == LEN_HI) || (state == DATA) ||
                    (state == WRITE)  || (state == CSUM);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      mem_wen    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_resetn <= 1'b0;
      boot_busy  <= 1'b0;
      boot_err   <= 1'b0;
      len_lo     <= '0;
      len        <= '0;
      idx        <= '0;
      bi         <= '0;
      sum        <= '0;
      wbuf       <= '0;
`ifdef BOOT_TIMEOUT_EN
      to_cnt     <= '0;
      magic_seen <= 1'b0;
`endif
    end else begin
      mem_wen <= '0;
      case (state)
        // ERROR is a resting state that accepts a new frame just like IDLE.
        IDLE, ERROR: begin
          if (rx_valid && rx_byte == BOOT_MAGIC) begin
            state     <= LEN_LO;
            boot_err  <= 1'b0;
            boot_busy <= 1'b1;
`ifdef BOOT_TIMEOUT_EN
            magic_seen <= 1'b1;
`endif
          end
`ifdef BOOT_TIMEOUT_EN
          else if (state == IDLE && !magic_seen) begin
            if (to_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
              state      <= DONE;
              cpu_resetn <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 32'd1;
            end
          end
`endif
        end
        LEN_LO: if (rx_valid) begin
          len_lo <= rx_byte;
          state  <= LEN_HI;
        end
        LEN_HI: if (rx_valid) begin
          sum <= '0;
          idx <= '0;
          bi  <= '0;
          len <= len_full[CW-1:0];  // only kept when bounded by WORDS
          if (len_full > WORDS16) begin
            state     <= ERROR;
            boot_err  <= 1'b1;
            boot_busy <= 1'b0;
          end else if (len_full == 16'd0) begin
            state <= CSUM;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (rx_valid) begin
          wbuf <= word_nxt;
          sum  <= sum + rx_byte;
          bi   <= bi + 2'd1;
          if (bi == 2'd3) begin
            state     <= WRITE;
            mem_wen   <= 4'hF;
            mem_addr  <= idx[ADDR_W-1:0];
            mem_wdata <= word_nxt;
          end
        end
        WRITE: begin
          idx   <= idx_nxt;
          state <= (idx_nxt == len) ? CSUM : DATA;
        end
        CSUM: if (rx_valid) begin
          boot_busy <= 1'b0;
          if (rx_byte == sum) begin
            state      <= DONE;
            cpu_resetn <= 1'b1;
          end else begin
            state    <= ERROR;
            boot_err <= 1'b1;
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase

      // A framing error anywhere inside a frame aborts it; overrides the case above.
      if (rx_ferr && in_frame) begin
        state     <= ERROR;
        boot_err  <= 1'b1;
        boot_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
`timescale 1ns/1ps
module tb_uart_boot_loader;
  import boot_pkg::*;

  localparam int CLK_DIV = 16;
  localparam int WORDS   = 512;
  localparam int ADDR_W  = 9;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              uart_rx = 1'b1;
  logic [3:0]        mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_resetn, boot_busy, boot_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_boot_loader #(
    .CLK_DIV(CLK_DIV), .WORDS(WORDS), .ADDR_W(ADDR_W)
`ifdef BOOT_TIMEOUT_EN
    , .TIMEOUT_CYCLES(1000)
`endif
  ) dut (
    .clk(clk), .resetn(resetn), .uart_rx(uart_rx),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_resetn(cpu_resetn), .boot_busy(boot_busy), .boot_err(boot_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- write monitor ----------------
  typedef struct { logic [ADDR_W-1:0] a; logic [31:0] d; } wr_t;
  wr_t got_wr[$];
  wr_t exp_wr[$];

  // Every cycle with any enable set is logged, so a pulse longer than one
  // cycle shows up as an extra write.
  always @(negedge clk) begin
    if (resetn && mem_wen != 4'h0) begin
      chk("wen_mask", 32'(mem_wen), 32'hF);
      got_wr.push_back('{mem_addr, mem_wdata});
    end
  end

  // ---------------- UART BFM ----------------
  logic [7:0] sb[$];
  bit         sf[$];

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    uart_rx = 1'b0;
    repeat (CLK_DIV) @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      uart_rx = b[k];
      repeat (CLK_DIV) @(posedge clk);
    end
    uart_rx = bad_stop ? 1'b0 : 1'b1;
    repeat (CLK_DIV) @(posedge clk);
    uart_rx = 1'b1;
    repeat (CLK_DIV) @(posedge clk);
  endtask

  task automatic send_stream();
    for (int k = 0; k < sb.size(); k++) send_byte(sb[k], sf[k]);
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // Parses the whole byte stream as frames: hunt for magic, read header,
  // emit complete words, judge the checksum. Framing errors truncate a frame.
  bit m_done, m_err, m_busy;

  task automatic model_run(input logic [7:0] b[$], input bit f[$]);
    int n, i, s, fe, avail, len, nw;
    logic [7:0] sum;
    n = b.size();
    i = 0;
    while (i < n && !m_done) begin
      if (f[i] || b[i] != BOOT_MAGIC) i++;
      else begin
        m_busy = 1; m_err = 0; s = i;
        fe = n;
        for (int k = n - 1; k > s; k--) if (f[k]) fe = k;
        avail = fe - s - 1;
        if (avail < 2) begin
          if (fe < n) begin m_busy = 0; m_err = 1; end
          i = fe + 1;
        end else begin
          len = int'(b[s+1]) + 256 * int'(b[s+2]);
          if (len > WORDS) begin
            m_busy = 0; m_err = 1; i = s + 3;
          end else begin
            nw = (avail - 2) / 4;
            if (nw > len) nw = len;
            for (int w = 0; w < nw; w++)
              exp_wr.push_back('{ADDR_W'(w),
                {b[s+6+4*w], b[s+5+4*w], b[s+4+4*w], b[s+3+4*w]}});
            if (avail >= 3 + 4 * len) begin
              sum = 8'h00;
              for (int k = 0; k < 4 * len; k++) sum += b[s+3+k];
              m_busy = 0;
              if (sum == b[s+3+4*len]) m_done = 1; else m_err = 1;
              i = s + 4 + 4 * len;
            end else begin
              if (fe < n) begin m_busy = 0; m_err = 1; end
              i = fe + 1;
            end
          end
        end
      end
    end
  endtask

  task automatic cmp_writes(input string tag);
    chk({tag, " nwr"}, got_wr.size(), exp_wr.size());
    for (int k = 0; k < got_wr.size() && k < exp_wr.size(); k++) begin
      chk({tag, " addr"}, 32'(got_wr[k].a), 32'(exp_wr[k].a));
      chk({tag, " data"}, got_wr[k].d, exp_wr[k].d);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    uart_rx = 1'b1;
    m_done = 0; m_err = 0; m_busy = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic clear_bufs();
    got_wr.delete(); exp_wr.delete(); sb.delete(); sf.delete();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string        name;
    bit           rst;
    int           n;
    logic [127:0] bytes;    // first byte in the most significant used position
    int           ferr_at;  // byte index sent with a low stop bit, -1 for none
    bit           e_cpu, e_err, e_busy;
  } vec_t;

  localparam int NV = 8;
  vec_t tv[NV];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // 8-bit sum of 78 56 34 12 EF BE AD DE is 0x4C.
    tv[0] = '{"good2",   1, 12, 128'({8'hA5,8'h02,8'h00,8'h78,8'h56,8'h34,8'h12,8'hEF,8'hBE,8'hAD,8'hDE,8'h4C}), -1, 1, 0, 0};
    tv[1] = '{"badsum",  1, 12, 128'({8'hA5,8'h02,8'h00,8'h78,8'h56,8'h34,8'h12,8'hEF,8'hBE,8'hAD,8'hDE,8'h4D}), -1, 0, 1, 0};
    tv[2] = '{"resend",  0, 12, 128'({8'hA5,8'h02,8'h00,8'h78,8'h56,8'h34,8'h12,8'hEF,8'hBE,8'hAD,8'hDE,8'h4C}), -1, 1, 0, 0};
    tv[3] = '{"len513",  1, 3,  128'({8'hA5,8'h01,8'h02}), -1, 0, 1, 0};
    tv[4] = '{"len0",    0, 4,  128'({8'hA5,8'h00,8'h00,8'h00}), -1, 1, 0, 0};
    tv[5] = '{"ferr",    1, 6,  128'({8'hA5,8'h01,8'h00,8'h78,8'h56,8'h34}), 5, 0, 1, 0};
    tv[6] = '{"garbage", 1, 2,  128'({8'h11,8'h22}), -1, 0, 0, 0};
    tv[7] = '{"partial", 0, 3,  128'({8'hA5,8'h01,8'h00}), -1, 0, 0, 1};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst mem_wen", 32'(mem_wen), 0);
    chk("rst mem_addr", 32'(mem_addr), 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst cpu_resetn", 32'(cpu_resetn), 0);
    chk("rst boot_busy", 32'(boot_busy), 0);
    chk("rst boot_err", 32'(boot_err), 0);

`ifdef BOOT_TIMEOUT_EN
    // Silent line: release at cycle 1000 after reset.
    do_reset();
    repeat (999) @(posedge clk);
    #1 chk("to before", 32'(cpu_resetn), 0);
    @(posedge clk);
    #1 chk("to at 1000", 32'(cpu_resetn), 1);
    chk("to err", 32'(boot_err), 0);
    // Magic at cycle 500 freezes the counter.
    do_reset();
    repeat (500) @(posedge clk);
    send_byte(BOOT_MAGIC, 0);
    repeat (700) @(posedge clk);
    @(negedge clk);
    chk("to frozen cpu", 32'(cpu_resetn), 0);
    chk("to frozen busy", 32'(boot_busy), 1);
`endif

    // Table-driven frames
    for (int t = 0; t < NV; t++) begin
      if (tv[t].rst) do_reset();
      clear_bufs();
      for (int k = 0; k < tv[t].n; k++) begin
        sb.push_back(tv[t].bytes[8*(tv[t].n-1-k) +: 8]);
        sf.push_back(k == tv[t].ferr_at);
      end
      model_run(sb, sf);
      send_stream();
      chk({tv[t].name, " cpu_resetn"}, 32'(cpu_resetn), 32'(tv[t].e_cpu));
      chk({tv[t].name, " boot_err"}, 32'(boot_err), 32'(tv[t].e_err));
      chk({tv[t].name, " boot_busy"}, 32'(boot_busy), 32'(tv[t].e_busy));
      cmp_writes(tv[t].name);
    end

    // Async reset in the middle of DATA, after one word already written
    do_reset();
    clear_bufs();
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0);
    send_byte(8'h12, 0); send_byte(8'hEF, 0);
    @(negedge clk);
    chk("mid busy", 32'(boot_busy), 1);
    chk("mid wdata", mem_wdata, 32'h12345678);
    #2 resetn = 1'b0;
    #1;
    chk("async wen", 32'(mem_wen), 0);
    chk("async addr", 32'(mem_addr), 0);
    chk("async wdata", mem_wdata, 0);
    chk("async cpu", 32'(cpu_resetn), 0);
    chk("async busy", 32'(boot_busy), 0);
    chk("async err", 32'(boot_err), 0);
    @(negedge clk);
    resetn = 1'b1;
    got_wr.delete();
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h78, 0); send_byte(8'h56, 0); send_byte(8'h34, 0); send_byte(8'h12, 0);
    send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 0);
    chk("pre csum cpu", 32'(cpu_resetn), 0);
    send_byte(8'h4C, 0);
    chk("post csum cpu", 32'(cpu_resetn), 1);
    chk("post nwr", got_wr.size(), 2);
    if (got_wr.size() == 2) begin
      chk("post w1", got_wr[1].d, 32'hDEADBEEF);
      chk("post a1", 32'(got_wr[1].a), 1);
    end
    chk("hold addr", 32'(mem_addr), 1);
    chk("hold wdata", mem_wdata, 32'hDEADBEEF);

    // Randomised frames against the model
    for (int r = 0; r < 10; r++) begin
      int   len;
      logic [7:0] csum, d;
      do_reset();
      clear_bufs();
      if ($urandom_range(0, 3) == 0) begin
        sb.push_back(8'($urandom_range(0, 127)));
        sf.push_back($urandom_range(0, 1) == 1);
      end
      len = ($urandom_range(0, 7) == 0) ? 513 + $urandom_range(0, 5) : $urandom_range(0, 3);
      sb.push_back(BOOT_MAGIC); sf.push_back(0);
      sb.push_back(8'(len));    sf.push_back(0);
      sb.push_back(8'(len >> 8)); sf.push_back(0);
      csum = 8'h00;
      for (int k = 0; k < ((len > WORDS) ? 2 : 4 * len); k++) begin
        d = 8'($urandom);
        csum += d;
        sb.push_back(d); sf.push_back(0);
      end
      if (len <= WORDS) begin
        sb.push_back(($urandom_range(0, 3) == 0) ? csum + 8'd1 : csum);
        sf.push_back(0);
      end
      if ($urandom_range(0, 4) == 0) sf[$urandom_range(1, sb.size() - 1)] = 1;
      model_run(sb, sf);
      send_stream();
      chk($sformatf("rnd%0d cpu", r), 32'(cpu_resetn), 32'(m_done));
      chk($sformatf("rnd%0d err", r), 32'(boot_err), 32'(m_err));
      chk($sformatf("rnd%0d busy", r), 32'(boot_busy), 32'(m_busy));
      cmp_writes($sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
